// File: rtl/usbf_utmi_tx_pkg.sv
// usbf_utmi_tx_pkg: shared constants for the UTMI tx adapter
// one-hot state encodings, byte and counter widths
package usbf_utmi_tx_pkg;

  localparam int BYTE_W = 8;
  localparam int BCNT_W = 11;

  localparam logic [BCNT_W-1:0] BCNT_MAX = '1;

  localparam int S_IDLE = 0;
  localparam int S_FILL = 1;
  localparam int S_SEND = 2;
  localparam int S_GAP  = 3;

  localparam logic [3:0] UTX_IDLE = 4'b0001;
  localparam logic [3:0] UTX_FILL = 4'b0010;
  localparam logic [3:0] UTX_SEND = 4'b0100;
  localparam logic [3:0] UTX_GAP  = 4'b1000;

endpackage

// File: rtl/usbf_utmi_tx_if.sv
// usbf_utmi_tx_if: byte stream from packet assembler
// master = assembler, slave = utmi tx adapter
interface usbf_utmi_tx_if;
  import usbf_utmi_tx_pkg::*;

  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_valid_last;
  logic              tx_first;
  logic              tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    output tx_valid_last,
    output tx_first,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    input  tx_valid_last,
    input  tx_first,
    output tx_ready
  );

endinterface

// File: rtl/usbf_utmi_tx_fifo.sv
// usbf_utmi_tx_fifo: small sync byte FIFO
// storage is unreset; only pointers/count clear
module usbf_utmi_tx_fifo
  import usbf_utmi_tx_pkg::*;
#(
  parameter int AW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic [AW:0]       cnt
);

  localparam int DEPTH = 1 << AW;

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;

  assign dout  = mem[rptr];
  assign empty = (cnt == '0);
  assign full  = (cnt == (AW+1)'(DEPTH));

  // byte storage write port
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  // pointers wrap modulo depth; flush drops all
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/usbf_utmi_tx.sv
// usbf_utmi_tx: UTMI transmit adapter
// buffers assembler bytes, drives PHY, enforces IPG
module usbf_utmi_tx
  import usbf_utmi_tx_pkg::*;
#(
  parameter int FIFO_AW    = 2,
  parameter int PRIME_LVL  = 2,
  parameter int IPG_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  usbf_utmi_tx_if.slave     up,
  input  logic              phy_rx_active,
  output logic [BYTE_W-1:0] DataOut,
  output logic              TxValid,
  input  logic              TxReady,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              tx_underrun,
  output logic [BCNT_W-1:0] tx_byte_cnt
);

  localparam logic [FIFO_AW:0] PRIME =
    (FIFO_AW+1)'(PRIME_LVL);
  localparam logic [7:0] GAP_LD =
    8'(IPG_CYCLES - 1);

  logic [3:0]       state;
  logic [3:0]       state_n;
  logic             last_in;
  logic             last_n;
  logic [7:0]       gap_cnt;
  logic [FIFO_AW:0] cnt;
  logic [FIFO_AW:0] cnt_fill;
  logic             empty;
  logic             full;
  logic             ready;
  logic             push;
  logic             pop;

  assign up.tx_ready  = ready;
  assign push         = up.tx_valid & ready;
  assign pop          = TxValid & TxReady & !empty;
  assign cnt_fill     = cnt + {{FIFO_AW{1'b0}}, push};
  assign last_n       = last_in
                      | (push & up.tx_valid_last);
  assign tx_busy      = !state[S_IDLE];
  assign tx_done      = state[S_SEND] & pop & last_in
                      & (cnt == (FIFO_AW+1)'(1));
  assign tx_underrun  = state[S_SEND] & empty
                      & !last_in & !push;

  usbf_utmi_tx_fifo #(
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (tx_underrun),
    .din   (up.tx_data),
    .dout  (DataOut),
    .empty (empty),
    .full  (full),
    .cnt   (cnt)
  );

  // upstream acceptance; no path from TxReady
  always_comb begin
    ready = 1'b0;
    unique case (1'b1)
      state[S_IDLE]: ready = up.tx_valid
                           & up.tx_first
                           & !phy_rx_active
                           & !full;
      state[S_FILL]: ready = !full & !last_in;
      state[S_SEND]: ready = !full & !last_in;
      default:       ready = 1'b0;
    endcase
  end

  // next state; FILL looks at post-push occupancy
  always_comb begin
    state_n = state;
    unique case (1'b1)
      state[S_IDLE]:
        if (push) state_n = UTX_FILL;
      state[S_FILL]:
        if (cnt_fill >= PRIME || last_n)
          state_n = UTX_SEND;
      state[S_SEND]:
        if (tx_done || tx_underrun)
          state_n = UTX_GAP;
      state[S_GAP]:
        if (gap_cnt == 8'd0) state_n = UTX_IDLE;
      default: state_n = UTX_IDLE;
    endcase
  end

  // state and TxValid; reset drops TxValid at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= UTX_IDLE;
      TxValid <= 1'b0;
    end else begin
      state   <= state_n;
      TxValid <= state_n[S_SEND];
    end
  end

  // last byte of the packet has been buffered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      last_in <= 1'b0;
    else if (state[S_GAP])
      last_in <= 1'b0;
    else if (push && up.tx_valid_last)
      last_in <= 1'b1;
  end

  // inter-packet gap; preloaded outside GAP
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      gap_cnt <= 8'd0;
    else if (!state[S_GAP])
      gap_cnt <= GAP_LD;
    else if (gap_cnt != 8'd0)
      gap_cnt <= gap_cnt - 8'd1;
  end

  // popped-byte count, held until next tx_first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      tx_byte_cnt <= '0;
    else if (state[S_IDLE] && push)
      tx_byte_cnt <= '0;
    else if (pop && tx_byte_cnt != BCNT_MAX)
      tx_byte_cnt <= tx_byte_cnt + 1'b1;
  end

endmodule

// File: tb/tb_usbf_utmi_tx.sv
// tb_usbf_utmi_tx: scoreboard bench for usbf_utmi_tx
// directed scenarios plus randomized packets
module tb_usbf_utmi_tx;

  typedef struct {
    logic [7:0] d;
    bit         last;
    int         idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        phy_rx_active = 1'b0;
  logic        TxReady = 1'b0;
  logic [7:0]  DataOut;
  logic        TxValid;
  logic        tx_busy;
  logic        tx_done;
  logic        tx_underrun;
  logic [10:0] tx_byte_cnt;

  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;
  int   un_cnt = 0;
  int   exp_done = 0;
  int   acc_cnt = 0;
  int   txr_mode = 0;
  bit   txr_fix = 1'b1;
  bit   rx_mode = 1'b0;
  bit   fin_pend = 1'b0;
  bit   un_pend = 1'b0;
  int   fin_val = 0;
  exp_t exp_q[$];

  usbf_utmi_tx_if up ();

  usbf_utmi_tx dut (
    .clk           (clk),
    .rst           (rst),
    .up            (up),
    .phy_rx_active (phy_rx_active),
    .DataOut       (DataOut),
    .TxValid       (TxValid),
    .TxReady       (TxReady),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done),
    .tx_underrun   (tx_underrun),
    .tx_byte_cnt   (tx_byte_cnt)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int v);
    return (v > 2047) ? 2047 : v;
  endfunction

  task automatic chk(input string nm,
                     input longint act,
                     input longint req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h",
               nm, act, req);
    end
  endtask

  task automatic idle_inputs();
    up.tx_valid      = 1'b0;
    up.tx_first      = 1'b0;
    up.tx_valid_last = 1'b0;
  endtask

  // queue the packet in the scoreboard, then hand it over byte by byte
  task automatic send_pkt(input logic [7:0] b[$],
                          input bit has_last);
    int t;
    for (int i = 0; i < b.size(); i++)
      exp_q.push_back('{b[i],
        has_last && (i == b.size() - 1), i});
    if (has_last) exp_done++;
    for (int i = 0; i < b.size(); i++) begin
      up.tx_data       = b[i];
      up.tx_valid      = 1'b1;
      up.tx_first      = (i == 0);
      up.tx_valid_last = has_last && (i == b.size() - 1);
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!up.tx_ready && t < 300);
      if (!up.tx_ready) begin
        tests++;
        fails++;
        $display("FAIL hs_timeout: byte %0d not taken in %0d cycles",
                 i, t);
      end else begin
        acc_cnt++;
      end
      @(posedge clk);
      #1;
    end
    idle_inputs();
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx_busy && n < 5000);
    chk({nm, "_idle_timeout"}, tx_busy, 0);
    @(posedge clk);
    #1;
  endtask

  // PHY side: TxReady pattern and random RxActive
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (txr_mode)
        1:       TxReady = ($urandom_range(0, 3) != 0);
        2:       TxReady = ~TxReady;
        default: TxReady = txr_fix;
      endcase
      if (rx_mode)
        phy_rx_active = ($urandom_range(0, 3) == 0);
    end
  end

  // monitor: every PHY pop is checked against the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    bit   exp_dn;
    if (!rst) begin
      fin_pend = 1'b0;
      un_pend  = 1'b0;
    end else begin
      if (fin_pend) begin
        chk("final_cnt", tx_byte_cnt, fin_val);
        chk("done_txv_off", TxValid, 0);
        fin_pend = 1'b0;
      end
      if (un_pend) begin
        chk("urun_txv_off", TxValid, 0);
        chk("urun_in_gap", tx_busy, 1);
        un_pend = 1'b0;
      end
      exp_dn = 1'b0;
      if (TxValid && TxReady && !tx_underrun) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_byte: got %02h, none expected",
                   DataOut);
        end else begin
          e = exp_q.pop_front();
          exp_dn = e.last;
          chk("data", DataOut, e.d);
          chk("bcnt", tx_byte_cnt, sat(e.idx));
          if (e.last) begin
            fin_pend = 1'b1;
            fin_val  = sat(e.idx + 1);
          end
        end
      end
      chk("done", tx_done, exp_dn);
      if (tx_done) done_cnt++;
      if (tx_underrun) begin
        un_cnt++;
        un_pend = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] pk[$];
    int n;
    int n0;
    int u0;
    up.tx_data = 8'h00;
    idle_inputs();

    repeat (3) @(negedge clk);
    chk("rst_txvalid", TxValid, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_urun", tx_underrun, 0);
    chk("rst_cnt", tx_byte_cnt, 0);
    chk("rst_ready", up.tx_ready, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // token, then a second token held through the gap
    pk = '{8'hD2};
    send_pkt(pk, 1'b1);
    up.tx_data       = 8'h2D;
    up.tx_valid      = 1'b1;
    up.tx_first      = 1'b1;
    up.tx_valid_last = 1'b1;
    exp_q.push_back('{8'h2D, 1'b1, 0});
    exp_done++;
    @(negedge clk);
    chk("t1_c1_txvalid", TxValid, 0);
    chk("t1_late_ready", up.tx_ready, 0);
    @(negedge clk);
    chk("t1_c2_txvalid", TxValid, 1);
    chk("t1_c2_data", DataOut, 8'hD2);
    n = 0;
    while (!up.tx_ready && n < 50) begin
      @(negedge clk);
      if (!up.tx_ready) n++;
    end
    chk("t1_gap_len", n, 8);
    @(posedge clk);
    #1;
    idle_inputs();
    wait_idle("t1");
    chk("t1_cnt", tx_byte_cnt, 1);

    // DATA0 with toggling TxReady
    txr_mode = 2;
    n0 = done_cnt;
    pk = '{8'hC3, 8'h01, 8'h02, 8'hAB, 8'hCD};
    send_pkt(pk, 1'b1);
    wait_idle("t2");
    chk("t2_cnt", tx_byte_cnt, 5);
    chk("t2_one_done", done_cnt - n0, 1);

    // underrun: no last byte ever arrives
    txr_mode = 0;
    txr_fix  = 1'b1;
    n0 = done_cnt;
    u0 = un_cnt;
    pk = '{8'hC3, 8'h11};
    send_pkt(pk, 1'b0);
    wait_idle("t3");
    chk("t3_urun", un_cnt - u0, 1);
    chk("t3_no_done", done_cnt - n0, 0);
    chk("t3_drained", exp_q.size(), 0);

    // RxActive holds off a new packet
    phy_rx_active = 1'b1;
    pk = '{8'h5A};
    fork
      send_pkt(pk, 1'b1);
      begin
        repeat (4) begin
          @(negedge clk);
          chk("t4_rdy_blocked", up.tx_ready, 0);
          chk("t4_txv_low", TxValid, 0);
        end
        @(posedge clk);
        #1;
        phy_rx_active = 1'b0;
        @(negedge clk);
        chk("t4_rdy_release", up.tx_ready, 1);
      end
    join
    wait_idle("t4");

    // PHY backpressure with a 10-byte packet
    txr_fix = 1'b0;
    acc_cnt = 0;
    pk = {};
    for (int i = 0; i < 10; i++)
      pk.push_back(8'($urandom));
    fork
      send_pkt(pk, 1'b1);
      begin
        repeat (12) @(negedge clk);
        chk("t5_accepted", acc_cnt, 4);
        chk("t5_rdy_full", up.tx_ready, 0);
        chk("t5_txv", TxValid, 1);
        txr_fix = 1'b1;
      end
    join
    wait_idle("t5");
    chk("t5_cnt", tx_byte_cnt, 10);

    // asynchronous reset in the middle of SEND
    txr_fix = 1'b0;
    pk = '{8'h77, 8'h88, 8'h99};
    send_pkt(pk, 1'b1);
    @(negedge clk);
    chk("t6_pre_txv", TxValid, 1);
    #2 rst = 1'b0;
    #1;
    chk("t6_txv", TxValid, 0);
    chk("t6_busy", tx_busy, 0);
    chk("t6_cnt", tx_byte_cnt, 0);
    exp_q.delete();
    exp_done--;
    txr_fix = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    pk = '{8'hD2};
    send_pkt(pk, 1'b1);
    wait_idle("t6");
    chk("t6_post_cnt", tx_byte_cnt, 1);

    // byte counter saturation
    pk = {};
    for (int i = 0; i < 2050; i++)
      pk.push_back(8'(i * 7 + 3));
    send_pkt(pk, 1'b1);
    wait_idle("sat");
    chk("sat_cnt", tx_byte_cnt, 2047);

    // random packets, random TxReady and RxActive
    txr_mode = 1;
    rx_mode  = 1'b1;
    for (int p = 0; p < 30; p++) begin
      pk = {};
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++)
        pk.push_back(8'($urandom));
      send_pkt(pk, 1'b1);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    rx_mode = 1'b0;
    phy_rx_active = 1'b0;
    wait_idle("rand");
    repeat (2) @(negedge clk);

    chk("all_done", done_cnt, exp_done);
    chk("all_urun", un_cnt, 1);
    chk("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
